// File: rtl/dataout_sink_if.sv
// Ejection-port bundle for dataout_sink: the inbound flit strobe and the
// capture-buffer read port.
interface dataout_sink_if #(
    parameter int ADDR_W = 5
);
    logic [19:0]       datain;
    logic              in_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [19:0]       rd_data;
    logic              rd_valid;

    modport master (
        output datain, in_valid, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  datain, in_valid, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/dataout_sink.sv
// NoC ejection-port traffic sink: counts, checks and captures 20-bit flits.
// Optional idle watchdog enabled by defining DATAOUT_SINK_TIMEOUT_EN.
module dataout_sink #(
    parameter logic [1:0] NODE_CLUSTER = 2'd0,
    parameter logic [1:0] NODE_LOCAL   = 2'd0,
    parameter int         EXPECTED     = 30,
    parameter int         DEPTH        = 32,
    parameter int         ADDR_W       = 5,
    parameter int         TIMEOUT      = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clr,
    dataout_sink_if.slave      bus,
    output logic [15:0]        rx_count,
    output logic [15:0]        misroute_count,
    output logic [15:0]        payload_sum,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               extra_flit,
    output logic               timeout
);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    localparam logic [15:0]     EXPECTED_W = 16'(EXPECTED);
    localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   wr_ptr;
    logic [19:0]       mem [DEPTH];
    logic              accept, buf_free, is_misroute, last_flit, idle_expired;
    logic [15:0]       rx_inc;

    assign accept      = (state == RECV) && bus.in_valid && !clr;
    assign buf_free    = wr_ptr < DEPTH_W;
    assign is_misroute = (bus.datain[3:2] != NODE_CLUSTER) || (bus.datain[1:0] != NODE_LOCAL);
    assign rx_inc      = (rx_count == 16'hFFFF) ? rx_count : rx_count + 16'd1;
    assign last_flit   = accept && (rx_inc == EXPECTED_W);
    assign busy        = (state == RECV);
    assign done        = (state == DONE);

`ifdef DATAOUT_SINK_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);
    logic [15:0] idle_cnt;

    // Expires on the edge where the counter would reach TIMEOUT.
    assign idle_expired = (state == RECV) && !accept && (idle_cnt + 16'd1 == TIMEOUT_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else if (clr) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state != RECV || accept) idle_cnt <= '0;
            else                         idle_cnt <= idle_cnt + 16'd1;
            if (idle_expired) timeout <= 1'b1;
        end
    end
`else
    assign idle_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = RECV;
            RECV: begin
                if (last_flit || idle_expired) state_nxt = DONE;
                else if (!enable)              state_nxt = IDLE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            rx_count       <= '0;
            misroute_count <= '0;
            payload_sum    <= '0;
            wr_ptr         <= '0;
            overflow       <= 1'b0;
            extra_flit     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clr) begin
                rx_count       <= '0;
                misroute_count <= '0;
                payload_sum    <= '0;
                wr_ptr         <= '0;
                overflow       <= 1'b0;
                extra_flit     <= 1'b0;
            end else begin
                if (accept) begin
                    rx_count    <= rx_inc;
                    payload_sum <= payload_sum + bus.datain[19:4];
                    if (is_misroute && misroute_count != 16'hFFFF)
                        misroute_count <= misroute_count + 16'd1;
                    if (buf_free) wr_ptr   <= wr_ptr + 1'b1;
                    else          overflow <= 1'b1;
                end
                if (state == DONE && bus.in_valid) extra_flit <= 1'b1;
            end
        end
    end

    // NOTE: the capture buffer has no reset; its contents survive reset and clr by design.
    always_ff @(posedge clk) begin
        if (accept && buf_free) mem[wr_ptr[ADDR_W-1:0]] <= bus.datain;
    end

    // Same-cycle write/read to one address returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            if (bus.rd_en)
                bus.rd_data <= ({1'b0, bus.rd_addr} < DEPTH_W) ? mem[bus.rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_dataout_sink.sv
// Self-checking bench for dataout_sink: table-driven flit run plus read-back scoreboard.
module tb_dataout_sink;

    typedef struct {
        logic [19:0] flit;
        logic [15:0] exp_rx;
        logic [15:0] exp_sum;
        logic        exp_done;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic enable_a, clr_a, enable_b, clr_b;
    logic [15:0] rx_a, mis_a, sum_a, rx_b, mis_b, sum_b;
    logic busy_a, done_a, ovf_a, extra_a, tmo_a;
    logic busy_b, done_b, ovf_b, extra_b, tmo_b;

    int total = 0;
    int passed = 0;
    logic [19:0] sb_a[$];
    logic [19:0] sb_b[$];
    vec_t vecs[30];

    always #5 clk = ~clk;

    dataout_sink_if #(.ADDR_W(5)) if_a ();
    dataout_sink_if #(.ADDR_W(6)) if_b ();

    dataout_sink #(.EXPECTED(30), .DEPTH(32), .ADDR_W(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .enable(enable_a), .clr(clr_a), .bus(if_a),
        .rx_count(rx_a), .misroute_count(mis_a), .payload_sum(sum_a),
        .busy(busy_a), .done(done_a), .overflow(ovf_a), .extra_flit(extra_a), .timeout(tmo_a)
    );

    dataout_sink #(.EXPECTED(40), .DEPTH(32), .ADDR_W(6), .TIMEOUT(16)) dut_ovf (
        .clk(clk), .rst(rst), .enable(enable_b), .clr(clr_b), .bus(if_b),
        .rx_count(rx_b), .misroute_count(mis_b), .payload_sum(sum_b),
        .busy(busy_b), .done(done_b), .overflow(ovf_b), .extra_flit(extra_b), .timeout(tmo_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [19:0] f);
        if_a.datain = f;
        if_a.in_valid = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [19:0] f);
        if_b.datain = f;
        if_b.in_valid = 1'b1;
        tick();
        if_b.in_valid = 1'b0;
    endtask

    task automatic read_a(input logic [4:0] addr, input logic [19:0] exp);
        if_a.rd_en = 1'b1;
        if_a.rd_addr = addr;
        sb_a.push_back(exp);
        tick();
        if_a.rd_en = 1'b0;
        check("rd_valid_a", if_a.rd_valid, 1);
    endtask

    task automatic read_b(input logic [5:0] addr, input logic [19:0] exp);
        if_b.rd_en = 1'b1;
        if_b.rd_addr = addr;
        sb_b.push_back(exp);
        tick();
        if_b.rd_en = 1'b0;
        check("rd_valid_b", if_b.rd_valid, 1);
    endtask

    task automatic stats_a(input string tag, input int rx, input int sum, input int mis,
                           input bit bz, input bit dn);
        check({tag, "_rx"}, rx_a, rx);
        check({tag, "_sum"}, sum_a, sum);
        check({tag, "_mis"}, mis_a, mis);
        check({tag, "_busy"}, busy_a, bz);
        check({tag, "_done"}, done_a, dn);
    endtask

    // Read-data scoreboard: pop an expectation for every rd_valid pulse.
    always @(negedge clk) begin
        if (if_a.rd_valid) begin
            if (sb_a.size() == 0) check("rd_a_spurious", if_a.rd_valid, 0);
            else check("rd_a_data", if_a.rd_data, sb_a.pop_front());
        end
        if (if_b.rd_valid) begin
            if (sb_b.size() == 0) check("rd_b_spurious", if_b.rd_valid, 0);
            else check("rd_b_data", if_b.rd_data, sb_b.pop_front());
        end
    end

    initial begin
        logic [15:0] run_sum;
        run_sum = '0;
        for (int i = 0; i < 30; i++) begin
            vecs[i].flit     = 20'((i + 1) << 4);
            run_sum          = run_sum + vecs[i].flit[19:4];
            vecs[i].exp_rx   = 16'(i + 1);
            vecs[i].exp_sum  = run_sum;
            vecs[i].exp_done = (i == 29);
        end

        rst = 1'b0;
        {enable_a, clr_a, enable_b, clr_b} = '0;
        if_a.datain = '0; if_a.in_valid = 1'b0; if_a.rd_en = 1'b0; if_a.rd_addr = '0;
        if_b.datain = '0; if_b.in_valid = 1'b0; if_b.rd_en = 1'b0; if_b.rd_addr = '0;
        tick();
        tick();
        stats_a("reset", 0, 0, 0, 0, 0);
        check("reset_ovf", ovf_a, 0);
        check("reset_extra", extra_a, 0);
        check("reset_tmo", tmo_a, 0);
        check("reset_rd_valid", if_a.rd_valid, 0);
        check("reset_rd_data", if_a.rd_data, 0);
        rst = 1'b1;
        tick();

        // Flits while idle are dropped, as is the flit on the arming edge.
        repeat (3) send_a(20'h00030);
        stats_a("prearm", 0, 0, 0, 0, 0);
        enable_a = 1'b1;
        send_a(20'h00990);
        stats_a("arm_edge", 0, 0, 0, 1, 0);

        for (int i = 0; i < 30; i++) begin
            send_a(vecs[i].flit);
            check($sformatf("vec%0d_rx", i), rx_a, vecs[i].exp_rx);
            check($sformatf("vec%0d_sum", i), sum_a, vecs[i].exp_sum);
            check($sformatf("vec%0d_done", i), done_a, vecs[i].exp_done);
            check($sformatf("vec%0d_busy", i), busy_a, !vecs[i].exp_done);
        end
        stats_a("main_end", 30, 16'h01D1, 0, 0, 1);
        read_a(5'd0, 20'h00010);
        read_a(5'd29, 20'h001E0);
        read_a(5'd14, 20'h000F0);

        send_a(20'h00400);
        check("extra_flag", extra_a, 1);
        stats_a("extra", 30, 16'h01D1, 0, 0, 1);

        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        stats_a("clr", 0, 0, 0, 0, 0);
        check("clr_extra", extra_a, 0);
        tick();
        check("rearm_busy", busy_a, 1);

        // Misrouted flits are still counted and stored.
        send_a(20'h00010);
        send_a(20'h00015);
        send_a(20'h0002A);
        send_a(20'h00020);
        stats_a("misroute", 4, 6, 2, 1, 0);
        read_a(5'd1, 20'h00015);
        read_a(5'd2, 20'h0002A);

        // Dropping enable holds statistics; re-arming resumes.
        enable_a = 1'b0;
        tick();
        stats_a("disarm", 4, 6, 2, 0, 0);
        send_a(20'h00100);
        stats_a("disarm_drop", 4, 6, 2, 0, 0);
        enable_a = 1'b1;
        tick();
        send_a(20'h00030);
        stats_a("resume", 5, 9, 2, 1, 0);
        read_a(5'd4, 20'h00030);

        // clr coincident with a flit discards it and resets the pointer.
        if_a.datain = 20'h00050;
        if_a.in_valid = 1'b1;
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        if_a.in_valid = 1'b0;
        stats_a("clr_flit", 0, 0, 0, 0, 0);
        tick();
        send_a(20'h00070);
        stats_a("post_clr", 1, 7, 0, 1, 0);
        read_a(5'd0, 20'h00070);

        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) send_a(20'(i << 4));
`ifdef DATAOUT_SINK_TIMEOUT_EN
        repeat (15) tick();
        check("tmo_early_done", done_a, 0);
        check("tmo_early_flag", tmo_a, 0);
        tick();
        check("tmo_flag", tmo_a, 1);
        stats_a("tmo", 5, 15, 0, 0, 1);
`else
        repeat (40) tick();
        check("notmo_flag", tmo_a, 0);
        stats_a("notmo", 5, 15, 0, 1, 0);
`endif
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("clr_tmo", tmo_a, 0);
        tick();

        // Asynchronous reset while flit 10 is on the wire.
        for (int i = 0; i < 9; i++) send_a(vecs[i].flit);
        check("pre_rst_rx", rx_a, 9);
        if_a.datain = vecs[9].flit;
        if_a.in_valid = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        stats_a("async_rst", 0, 0, 0, 0, 0);
        check("async_rst_ovf", ovf_a, 0);
        check("async_rst_tmo", tmo_a, 0);
        if_a.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) send_a(vecs[i].flit);
        stats_a("rerun", 30, 16'h01D1, 0, 0, 1);
        read_a(5'd29, 20'h001E0);

        // Overflow instance: 40 expected flits into a 32-entry buffer.
        enable_b = 1'b1;
        tick();
        for (int i = 1; i <= 40; i++) begin
            send_b(20'(i << 4));
            if (i == 32) check("ovf_at32", ovf_b, 0);
            if (i == 33) check("ovf_at33", ovf_b, 1);
        end
        check("ovf_rx", rx_b, 40);
        check("ovf_sum", sum_b, 16'h0334);
        check("ovf_done", done_b, 1);
        check("ovf_flag", ovf_b, 1);
        read_b(6'd31, 20'h00200);
        read_b(6'd40, 20'h00000);
        read_b(6'd0, 20'h00010);

        repeat (3) tick();
        check("sb_a_drain", sb_a.size(), 0);
        check("sb_b_drain", sb_b.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dataout_sink.md
Name: dataout_sink

Overview:
- Destination-side traffic sink: the receiving end of the 20-bit flit stream that the ROM injectors emit with a one-cycle valid strobe and no backpressure.
- Sits at a NoC node's local ejection port.
- Decodes each flit, checks its destination against the node's own address, and accumulates statistics.
- Stores received flits in a capture buffer that the testbench or a debug master reads back.

Parameters:
- NODE_CLUSTER, 0, this node's cluster ID (2 bits)
- NODE_LOCAL, 0, this node's local ID (2 bits)
- EXPECTED, 30, flit count that completes the run
- DEPTH, 32, capture buffer entries
- ADDR_W, 5, capture/read address width (must satisfy 2^ADDR_W >= DEPTH)
- TIMEOUT, 1024, idle-cycle watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- enable  in  1  arm receiver; level-sensitive
- clr  in  1  synchronous clear of statistics and buffer pointer; returns to IDLE
- datain  in  20  flit: [19:4] payload, [3:2] dest_cluster, [1:0] dest_local
- in_valid  in  1  flit strobe, one flit per cycle; cannot be stalled
- rd_en  in  1  capture buffer read request
- rd_addr  in  ADDR_W  capture buffer read address
- rd_data  out  20  read data
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- rx_count  out  16  flits accepted, saturating
- misroute_count  out  16  flits whose dest field does not match this node, saturating
- payload_sum  out  16  modulo-2^16 sum of accepted payloads
- busy  out  1  state is RECV
- done  out  1  EXPECTED flits accepted
- overflow  out  1  sticky; a flit was accepted with the buffer full
- extra_flit  out  1  sticky; in_valid seen while in DONE
- timeout  out  1  sticky; watchdog expired (constant 0 without the feature)

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; write pointer 0. Buffer contents are not cleared.
- States:
  - IDLE -> RECV when enable=1.
  - RECV -> DONE when the accepted count reaches EXPECTED.
  - RECV -> IDLE when enable=0; statistics are held and the next arm resumes counting.
  - DONE stays until clr or reset.
- Acceptance: a flit is accepted only in RECV with in_valid=1. The flit sampled in the IDLE->RECV transition cycle is ignored. Flits in IDLE are silently dropped.
- Per accepted flit, all registered with one-cycle latency to outputs:
  - rx_count += 1, saturating at 0xFFFF.
  - payload_sum += datain[19:4], wraps.
  - If datain[3:2] != NODE_CLUSTER or datain[1:0] != NODE_LOCAL: misroute_count += 1, saturating. The flit is still stored and counted.
  - If wr_ptr < DEPTH: store at wr_ptr, then wr_ptr += 1. Otherwise discard the data and set overflow.
- Completion: the flit that makes rx_count == EXPECTED also moves the state to DONE. done=1 and busy=0 in the cycle after that flit is sampled.
- DONE: in_valid sets extra_flit. No counters change.
- clr: has priority over everything else. In the clr cycle a flit is discarded. Counters, wr_ptr, done, overflow, extra_flit and timeout go to 0; state goes to IDLE.
- Read port: active in every state. On rd_en, rd_data <= buf[rd_addr] and rd_valid=1 on the next cycle. rd_addr >= DEPTH returns 0.
- A write and a read to the same address in the same cycle returns the old contents.
- Reset mid-run: everything aborts immediately; the flit in flight is lost.

Optional Feature:
- Macro: DATAOUT_SINK_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter runs in RECV only. It clears on every accepted flit and on entry to RECV.
  - When it reaches TIMEOUT, set timeout sticky and move to DONE with done=1, even though rx_count < EXPECTED.
  - clr clears the counter and the flag.
- Undefined: no counter is synthesized, timeout is tied to 0, and RECV waits indefinitely.

Test Plan:
- Arm, then inject 30 flits 0x00010, 0x00020, …, 0x001E0 back-to-back.
  -> rx_count=30, payload_sum=0x01D1, misroute_count=0, done=1 one cycle after the last flit.
  -> Reading address 0 gives 0x00010; reading address 29 gives 0x001E0 with rd_valid the following cycle.
- Inject 0x00015 (dest_local=1) among valid flits, NODE_LOCAL=0 -> misroute_count=1; the flit is stored and counted.
- EXPECTED=40, DEPTH=32, inject 40 flits -> overflow=1 after the 33rd flit, rx_count=40, done=1; address 31 holds the 32nd flit.
- Flits in IDLE, then arm -> pre-arm flits not counted.
  - clr asserted together with in_valid in RECV -> all stats 0, state IDLE, flit discarded.
  - One flit sent after done -> extra_flit=1, rx_count unchanged.
- With DATAOUT_SINK_TIMEOUT_EN and TIMEOUT=16: 5 flits then idle -> timeout=1 and done=1 16 cycles after the last flit; rx_count=5.
- Assert rst low mid-burst (flit 10) -> all outputs 0 immediately.
  - Release, arm, and send 30 flits -> normal completion with rx_count=30.
